// File: rtl/cal_edge_gen.sv
// cal_edge_gen: calibration edge generator for the sio carry-chain TDC.
// Emits bursts of square-wave edges with an exact half-period in clock cycles.
// Ports: c/r clock and sync reset; cmd_valid/cmd_ready/cmd_half/cmd_count
// command handshake; abort stops a burst; o edge output; busy/done/edges status.
// Optional macro CAL_EDGE_GEN_DITHER_EN adds LFSR half-period dither (+0/+1).
module cal_edge_gen #(
   parameter int HW = 8,
   parameter int CW = 16
) (
   input  logic          c,
   input  logic          r,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic [HW-1:0] cmd_half,
   input  logic [CW-1:0] cmd_count,
   input  logic          abort,
   output logic          o,
   output logic          busy,
   output logic          done,
   output logic [CW-1:0] edges
);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      END
   } state_t;

   state_t        state_q, state_d;
   logic [HW-1:0] timer_q, timer_d;
   logic [HW-1:0] half_q, half_d;
   logic [CW-1:0] count_q, count_d;
   logic [CW-1:0] edges_q, edges_d;
   logic          o_q, o_d;

   logic [HW-1:0] half_in;
   logic [HW-1:0] dith_now;
   logic [HW-1:0] dith_nxt;
   logic [CW-1:0] edges_inc;
   logic          last_edge;

   assign half_in   = (cmd_half == '0) ? HW'(1) : cmd_half;
   assign edges_inc = edges_q + CW'(1);
   // all-ones count means continuous; edges may wrap freely
   assign last_edge = (count_q != '1) && (edges_inc == count_q);

`ifdef CAL_EDGE_GEN_DITHER_EN
   logic [6:0] lfsr_q, lfsr_d, lfsr_nx;

   // x^7 + x^6 + 1, Fibonacci form
   assign lfsr_nx  = {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]};
   assign dith_now = {{(HW-1){1'b0}}, lfsr_q[0]};
   assign dith_nxt = {{(HW-1){1'b0}}, lfsr_nx[0]};
`else
   assign dith_now = '0;
   assign dith_nxt = '0;
`endif

   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      half_d  = half_q;
      count_d = count_q;
      edges_d = edges_q;
      o_d     = o_q;
`ifdef CAL_EDGE_GEN_DITHER_EN
      lfsr_d  = lfsr_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               half_d  = half_in;
               count_d = cmd_count;
               edges_d = '0;
               timer_d = half_in - HW'(1) + dith_now;
               state_d = (cmd_count == '0) ? END : RUN;
            end
         end
         RUN: begin
            // abort beats a timer expiry on the same edge
            if (abort) begin
               state_d = END;
            end else if (timer_q == '0) begin
               o_d     = ~o_q;
               edges_d = edges_inc;
               timer_d = half_q - HW'(1) + dith_nxt;
`ifdef CAL_EDGE_GEN_DITHER_EN
               lfsr_d  = lfsr_nx;
`endif
               if (last_edge) state_d = END;
            end else begin
               timer_d = timer_q - HW'(1);
            end
         end
         END: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge c) begin
      if (r) begin
         state_q <= IDLE;
         timer_q <= '0;
         half_q  <= '0;
         count_q <= '0;
         edges_q <= '0;
         o_q     <= 1'b0;
`ifdef CAL_EDGE_GEN_DITHER_EN
         lfsr_q  <= 7'h01;
`endif
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         half_q  <= half_d;
         count_q <= count_d;
         edges_q <= edges_d;
         o_q     <= o_d;
`ifdef CAL_EDGE_GEN_DITHER_EN
         lfsr_q  <= lfsr_d;
`endif
      end
   end

   assign cmd_ready = (state_q == IDLE);
   assign busy      = (state_q == RUN);
   assign done      = (state_q == END);
   assign o         = o_q;
   assign edges     = edges_q;

endmodule

// File: tb/tb_cal_edge_gen.sv
// tb_cal_edge_gen: directed table-driven bench for cal_edge_gen.
// Burst table plus hand sequences for held valid, dither and mid-burst reset.
module tb_cal_edge_gen;
   localparam int HW = 8;
   localparam int CW = 16;

   logic          c = 1'b0;
   logic          r;
   logic          cmd_valid;
   logic          cmd_ready;
   logic [HW-1:0] cmd_half;
   logic [CW-1:0] cmd_count;
   logic          abort;
   logic          o;
   logic          busy;
   logic          done;
   logic [CW-1:0] edges;

   int checks = 0;
   int errors = 0;

   cal_edge_gen #(.HW(HW), .CW(CW)) dut (
      .c(c), .r(r),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_half(cmd_half), .cmd_count(cmd_count),
      .abort(abort), .o(o), .busy(busy),
      .done(done), .edges(edges)
   );

   always #5 c = ~c;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge c);
      r = 1'b1;
      repeat (2) @(posedge c);
      @(negedge c);
      r = 1'b0;
   endtask

   typedef struct {
      int h;
      int cnt;
      int ab;
      int eff;
      int exp_edges;
      int exp_done;
   } vec_t;

   vec_t tbl[8];

   task automatic run_burst(input vec_t v, input string tag);
      int   k;
      int   nt;
      logic prev_o;
      logic start_o;
      bit   got;
      @(negedge c);
      start_o   = o;
      prev_o    = o;
      cmd_half  = HW'(v.h);
      cmd_count = CW'(v.cnt);
      cmd_valid = 1'b1;
      abort     = 1'b0;
      nt  = 0;
      got = 0;
      k   = 0;
      while (!got && k < 3000) begin
         @(posedge c);
         @(negedge c);
         cmd_valid = 1'b0;
         if (k == 0)
            chk({tag, "_busy0"}, 32'(busy), 32'(v.cnt != 0));
         if (o !== prev_o) begin
            nt++;
            chk({tag, "_tgl"}, 32'(k), 32'(nt * v.eff));
            prev_o = o;
         end
         if (done) begin
            got = 1;
            chk({tag, "_done_k"}, 32'(k), 32'(v.exp_done));
            chk({tag, "_busy_end"}, 32'(busy), 32'(0));
         end else begin
            abort = (k + 1 == v.ab);
            k++;
         end
      end
      abort = 1'b0;
      if (!got) chk({tag, "_timeout"}, 32'(0), 32'(1));
      chk({tag, "_edges"}, 32'(edges), 32'(v.exp_edges));
      chk({tag, "_ntgl"}, 32'(nt), 32'(v.exp_edges));
      chk({tag, "_o"}, 32'(o), 32'(start_o ^ v.exp_edges[0]));
      @(posedge c);
      @(negedge c);
      chk({tag, "_ready"}, 32'(cmd_ready), 32'(1));
      chk({tag, "_done_off"}, 32'(done), 32'(0));
   endtask

   initial begin
      logic [11:0] busy_pat;
      logic [11:0] o_pat;
      logic [11:0] done_pat;
      logic [6:0]  m;
      int          expi;
      int          last;
      int          nt;
      logic        prev_o;
      bit          got;
      bit          saw_done;

      tbl[0] = '{4, 6, -1, 4, 6, 24};
      tbl[1] = '{9, 0, -1, 9, 0, 0};
      tbl[2] = '{4, 100, 10, 4, 2, 10};
      tbl[3] = '{4, 100, 12, 4, 2, 12};
      tbl[4] = '{3, 5, 15, 3, 4, 15};
      tbl[5] = '{2, 65535, 9, 2, 4, 9};
      tbl[6] = '{0, 3, -1, 1, 3, 3};
      tbl[7] = '{1, 1, -1, 1, 1, 1};

      r         = 1'b1;
      cmd_valid = 1'b1;
      cmd_half  = 8'd3;
      cmd_count = 16'd4;
      abort     = 1'b0;
      repeat (3) @(posedge c);
      @(negedge c);
      chk("rst_o", 32'(o), 32'(0));
      chk("rst_ready", 32'(cmd_ready), 32'(1));
      chk("rst_busy", 32'(busy), 32'(0));
      chk("rst_done", 32'(done), 32'(0));
      chk("rst_edges", 32'(edges), 32'(0));
      r         = 1'b0;
      cmd_valid = 1'b0;

`ifndef CAL_EDGE_GEN_DITHER_EN
      for (int i = 0; i < 8; i++)
         run_burst(tbl[i], $sformatf("v%0d", i));

      do_reset();
      busy_pat  = 12'b0011_1100_1111;
      o_pat     = 12'b0011_0000_1100;
      done_pat  = 12'b0100_0001_0000;
      cmd_half  = 8'd2;
      cmd_count = 16'd2;
      cmd_valid = 1'b1;
      for (int k = 0; k < 12; k++) begin
         @(posedge c);
         @(negedge c);
         chk($sformatf("hold_busy%0d", k), 32'(busy), 32'(busy_pat[k]));
         chk($sformatf("hold_o%0d", k), 32'(o), 32'(o_pat[k]));
         chk($sformatf("hold_done%0d", k), 32'(done), 32'(done_pat[k]));
      end
      cmd_valid = 1'b0;
`endif

      do_reset();
      cmd_half  = 8'd5;
      cmd_count = 16'd127;
      cmd_valid = 1'b1;
      m      = 7'h01;
`ifdef CAL_EDGE_GEN_DITHER_EN
      expi   = 5 + int'(m[0]);
`else
      expi   = 5;
`endif
      last   = 0;
      nt     = 0;
      got    = 0;
      prev_o = o;
      for (int k = 0; k < 1500 && !got; k++) begin
         @(posedge c);
         @(negedge c);
         cmd_valid = 1'b0;
         if (o !== prev_o) begin
            nt++;
            chk($sformatf("dith_int%0d", nt), 32'(k - last), 32'(expi));
            last   = k;
            prev_o = o;
            m      = {m[5:0], m[6] ^ m[5]};
`ifdef CAL_EDGE_GEN_DITHER_EN
            expi   = 5 + int'(m[0]);
`endif
         end
         if (done) begin
            got = 1;
            chk("dith_done_k", 32'(k), 32'(last));
         end
      end
      if (!got) chk("dith_timeout", 32'(0), 32'(1));
      chk("dith_edges", 32'(edges), 32'(127));
      chk("dith_ntgl", 32'(nt), 32'(127));

      @(negedge c);
      cmd_half  = 8'd3;
      cmd_count = 16'd50;
      cmd_valid = 1'b1;
      @(posedge c);
      @(negedge c);
      cmd_valid = 1'b0;
      repeat (9) @(negedge c);
      chk("mid_busy", 32'(busy), 32'(1));
      r = 1'b1;
      @(posedge c);
      @(negedge c);
      r = 1'b0;
      chk("mid_o", 32'(o), 32'(0));
      chk("mid_busy_rst", 32'(busy), 32'(0));
      chk("mid_edges", 32'(edges), 32'(0));
      chk("mid_done", 32'(done), 32'(0));
      chk("mid_ready", 32'(cmd_ready), 32'(1));
      saw_done = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge c);
         if (done) saw_done = 1;
      end
      chk("mid_no_done", 32'(saw_done), 32'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
